// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-Lite master: a command/response port drives AXI-Lite
// read and write transactions, with a per-transaction timeout for hung slaves.
module axi_lite_master #(
   parameter int AXI_ADDRESS_WIDTH = 5,
   parameter int TIMEOUT_CYCLES    = 256
) (
   input  logic                         aclk,
   input  logic                         areset,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic                         cmd_write,
   input  logic [AXI_ADDRESS_WIDTH-1:0] cmd_addr,
   input  logic [31:0]                  cmd_wdata,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [31:0]                  rsp_rdata,
   output logic                         rsp_err,
   output logic [AXI_ADDRESS_WIDTH-1:0] maxi_awaddr,
   output logic                         maxi_awvalid,
   input  logic                         maxi_awready,
   output logic [31:0]                  maxi_wdata,
   output logic                         maxi_wvalid,
   input  logic                         maxi_wready,
   input  logic                         maxi_bvalid,
   output logic                         maxi_bready,
   output logic [AXI_ADDRESS_WIDTH-1:0] maxi_araddr,
   output logic                         maxi_arvalid,
   input  logic                         maxi_arready,
   input  logic [31:0]                  maxi_rdata,
   input  logic                         maxi_rvalid,
   output logic                         maxi_rready
);

   typedef enum logic [2:0] {
      IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP
   } state_t;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t                         state, state_nxt;
   logic                           aw_done, aw_done_nxt, w_done, w_done_nxt;
   logic [15:0]                    cnt, cnt_nxt;
   logic                           timeout;
   logic                           cmd_ready_nxt, rsp_valid_nxt, rsp_err_nxt;
   logic [31:0]                    rsp_rdata_nxt, wdata_nxt;
   logic [AXI_ADDRESS_WIDTH-1:0]   awaddr_nxt, araddr_nxt;
   logic                           awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt;

   assign timeout = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);

   always_ff @(posedge aclk) begin
      if (areset) begin
         state        <= IDLE;
         aw_done      <= 1'b0;
         w_done       <= 1'b0;
         cnt          <= '0;
         cmd_ready    <= 1'b1;
         rsp_valid    <= 1'b0;
         rsp_rdata    <= '0;
         rsp_err      <= 1'b0;
         maxi_awaddr  <= '0;
         maxi_wdata   <= '0;
         maxi_araddr  <= '0;
         maxi_awvalid <= 1'b0;
         maxi_wvalid  <= 1'b0;
         maxi_bready  <= 1'b0;
         maxi_arvalid <= 1'b0;
         maxi_rready  <= 1'b0;
      end else begin
         state        <= state_nxt;
         aw_done      <= aw_done_nxt;
         w_done       <= w_done_nxt;
         cnt          <= cnt_nxt;
         cmd_ready    <= cmd_ready_nxt;
         rsp_valid    <= rsp_valid_nxt;
         rsp_rdata    <= rsp_rdata_nxt;
         rsp_err      <= rsp_err_nxt;
         maxi_awaddr  <= awaddr_nxt;
         maxi_wdata   <= wdata_nxt;
         maxi_araddr  <= araddr_nxt;
         maxi_awvalid <= awvalid_nxt;
         maxi_wvalid  <= wvalid_nxt;
         maxi_bready  <= bready_nxt;
         maxi_arvalid <= arvalid_nxt;
         maxi_rready  <= rready_nxt;
      end
   end

   // Next-state and next-output logic; every output is registered from these values.
   always_comb begin
      state_nxt     = state;
      aw_done_nxt   = aw_done;
      w_done_nxt    = w_done;
      cnt_nxt       = cnt;
      cmd_ready_nxt = 1'b0;
      rsp_valid_nxt = 1'b0;
      rsp_rdata_nxt = rsp_rdata;
      rsp_err_nxt   = rsp_err;
      awaddr_nxt    = maxi_awaddr;
      wdata_nxt     = maxi_wdata;
      araddr_nxt    = maxi_araddr;
      awvalid_nxt   = 1'b0;
      wvalid_nxt    = 1'b0;
      bready_nxt    = 1'b0;
      arvalid_nxt   = 1'b0;
      rready_nxt    = 1'b0;

      if (state != IDLE && state != RESP) cnt_nxt = cnt + 16'd1;

      case (state)
         IDLE: begin
            cmd_ready_nxt = 1'b1;
            if (cmd_valid && cmd_ready) begin
               cmd_ready_nxt = 1'b0;
               cnt_nxt       = '0;
               aw_done_nxt   = 1'b0;
               w_done_nxt    = 1'b0;
               if (cmd_write) begin
                  state_nxt   = WR_ADDR_DATA;
                  awaddr_nxt  = cmd_addr;
                  wdata_nxt   = cmd_wdata;
                  awvalid_nxt = 1'b1;
                  wvalid_nxt  = 1'b1;
               end else begin
                  state_nxt   = RD_ADDR;
                  araddr_nxt  = cmd_addr;
                  arvalid_nxt = 1'b1;
               end
            end
         end
         WR_ADDR_DATA: begin
            aw_done_nxt = aw_done | (maxi_awvalid & maxi_awready);
            w_done_nxt  = w_done | (maxi_wvalid & maxi_wready);
            // Timeout is checked first so the counter cannot slip past its limit.
            if (timeout) begin
               state_nxt     = RESP;
               rsp_valid_nxt = 1'b1;
               rsp_err_nxt   = 1'b1;
               rsp_rdata_nxt = '0;
            end else if (aw_done_nxt && w_done_nxt) begin
               state_nxt  = WR_RESP;
               bready_nxt = 1'b1;
            end else begin
               awvalid_nxt = ~aw_done_nxt;
               wvalid_nxt  = ~w_done_nxt;
            end
         end
         WR_RESP: begin
            if (maxi_bvalid) begin
               state_nxt     = RESP;
               rsp_valid_nxt = 1'b1;
               rsp_err_nxt   = 1'b0;
               rsp_rdata_nxt = '0;
            end else if (timeout) begin
               state_nxt     = RESP;
               rsp_valid_nxt = 1'b1;
               rsp_err_nxt   = 1'b1;
               rsp_rdata_nxt = '0;
            end else begin
               bready_nxt = 1'b1;
            end
         end
         RD_ADDR: begin
            if (timeout) begin
               state_nxt     = RESP;
               rsp_valid_nxt = 1'b1;
               rsp_err_nxt   = 1'b1;
               rsp_rdata_nxt = '0;
            end else if (maxi_arready) begin
               state_nxt  = RD_DATA;
               rready_nxt = 1'b1;
            end else begin
               arvalid_nxt = 1'b1;
            end
         end
         RD_DATA: begin
            if (maxi_rvalid) begin
               state_nxt     = RESP;
               rsp_valid_nxt = 1'b1;
               rsp_err_nxt   = 1'b0;
               rsp_rdata_nxt = maxi_rdata;
            end else if (timeout) begin
               state_nxt     = RESP;
               rsp_valid_nxt = 1'b1;
               rsp_err_nxt   = 1'b1;
               rsp_rdata_nxt = '0;
            end else begin
               rready_nxt = 1'b1;
            end
         end
         RESP: begin
            rsp_valid_nxt = 1'b1;
            if (rsp_ready) begin
               state_nxt     = IDLE;
               rsp_valid_nxt = 1'b0;
               cmd_ready_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt     = IDLE;
            cmd_ready_nxt = 1'b1;
         end
      endcase
   end

endmodule
